// File: rtl/sound_mixer.sv
// Output audio stage: resamples the voice onto a fixed-rate strobe, removes DC,
// applies master volume with timed fades and per-channel gains with saturation.
module sound_mixer #(
  parameter int CLK_DIV = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         addr,
  input  logic [7:0]         data_in,
  input  logic               write,
  input  logic signed [11:0] audio_in,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               out_valid,
  output logic               fading
);

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else return v[15:0];
  endfunction

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0]        r_cnt;
  logic               w_strobe;
  logic [7:0]         r_cur_vol, r_tgt_vol, r_g_l, r_g_r, r_rate, r_fade_cnt;
  logic               r_mute, r_dc_en;
  logic               r_v0, r_v1, r_v2;
  logic signed [15:0] r_x, r_y, r_vol_out;
  logic signed [23:0] r_acc;

  assign w_strobe = (r_cnt == 16'd0);
  assign fading   = (r_cur_vol != r_tgt_vol);

  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + 16'd1;
  end

  // Fade stepping happens on output pulses; register writes below override it.
  logic [8:0] w_cnt_inc;
  logic       w_step;
  logic [7:0] w_vol_stepped;
  assign w_cnt_inc     = {1'b0, r_fade_cnt} + 9'd1;
  assign w_step        = out_valid && fading && (w_cnt_inc >= {1'b0, r_rate});
  assign w_vol_stepped = (r_cur_vol < r_tgt_vol) ? r_cur_vol + 8'd1 : r_cur_vol - 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_vol  <= 8'd255;
      r_tgt_vol  <= 8'd255;
      r_g_l      <= 8'd128;
      r_g_r      <= 8'd128;
      r_rate     <= 8'd0;
      r_fade_cnt <= 8'd0;
      r_mute     <= 1'b0;
      r_dc_en    <= 1'b1;
    end else begin
      if (out_valid && fading) begin
        if (w_step) begin
          r_cur_vol  <= w_vol_stepped;
          r_fade_cnt <= 8'd0;
        end else begin
          r_fade_cnt <= w_cnt_inc[7:0];
        end
      end
      if (write) begin
        case (addr)
          4'd0: begin
            r_cur_vol  <= data_in;
            r_tgt_vol  <= data_in;
            r_fade_cnt <= 8'd0;
          end
          4'd1: r_g_l <= data_in;
          4'd2: r_g_r <= data_in;
          4'd3: begin
            r_tgt_vol  <= data_in;
            r_fade_cnt <= 8'd0;
            r_cur_vol  <= (r_rate == 8'd0) ? data_in : r_cur_vol;
          end
          4'd4: begin
            r_rate     <= data_in;
            r_fade_cnt <= 8'd0;
          end
          4'd5: begin
            r_mute  <= data_in[0];
            r_dc_en <= data_in[1];
          end
          default: ;
        endcase
      end
    end
  end

  logic signed [15:0] w_m, w_y;
  logic signed [16:0] w_diff;
  logic signed [24:0] w_prod_v;
  assign w_m      = r_acc[23:8];
  assign w_diff   = 17'(r_x) - 17'(w_m);
  assign w_y      = r_dc_en ? sat16(18'(w_diff)) : r_x;
  assign w_prod_v = 25'(r_y) * 25'($signed({1'b0, r_cur_vol}));

  logic [7:0]         w_gain [2];
  logic signed [15:0] w_chan [2];
  assign w_gain[0] = r_g_l;
  assign w_gain[1] = r_g_r;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic signed [24:0] w_prod;
    assign w_prod     = 25'(r_vol_out) * 25'($signed({1'b0, w_gain[gi]}));
    assign w_chan[gi] = r_mute ? 16'sd0 : sat16(18'(w_prod >>> 7));
  end

  // One stage per cycle behind the strobe; valid bits flush on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_vol_out <= '0;
      r_acc     <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
    end else begin
      r_v0      <= w_strobe;
      r_v1      <= r_v0;
      r_v2      <= r_v1;
      out_valid <= r_v2;
      if (w_strobe) r_x <= {audio_in, 4'b0000};
      if (r_v0) begin
        r_y <= w_y;
        if (r_dc_en) r_acc <= r_acc + 24'(w_y);
      end
      if (r_v1) r_vol_out <= 16'(w_prod_v >>> 8);
      if (r_v2) begin
        audio_l <= w_chan[0];
        audio_r <= w_chan[1];
      end
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Scoreboard bench for sound_mixer: stimulus queues expected samples, a monitor
// pops and checks one entry per out_valid pulse.
module tb_sound_mixer;
  localparam int CLK_DIV   = 12;
  localparam int K_EXACT   = 0;
  localparam int K_DECAY   = 1;
  localparam int K_SETTLED = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         addr;
  logic [7:0]         data_in;
  logic               write;
  logic [11:0]        audio_in;
  logic signed [15:0] audio_l, audio_r;
  logic               out_valid, fading;

  typedef struct {
    int    kind;
    int    l;
    int    r;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   prev_l   = 0;
  logic prev_ov  = 1'b0;

  sound_mixer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write(write),
    .audio_in(audio_in), .audio_l(audio_l), .audio_r(audio_r),
    .out_valid(out_valid), .fading(fading)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 60000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   act_l, act_r;
    bit   ok;
    if (!reset && out_valid) begin
      n_checks++;
      if (prev_ov) begin
        n_fail++;
        $display("FAIL back_to_back_valid: out_valid high on consecutive cycles, required single-cycle pulse");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_l = audio_l;
        act_r = audio_r;
        case (e.kind)
          K_EXACT: ok = (act_l == e.l) && (act_r == e.r);
          K_DECAY: ok = (act_l == act_r) && (act_l >= 0) && (act_l <= prev_l);
          default: ok = (act_l == act_r) && (act_l < 64) && (act_l > -64);
        endcase
        n_checks++;
        if (!ok)
          $display("FAIL %s: L=%0d R=%0d, required kind=%0d L=%0d R=%0d (prev L=%0d)",
                   e.name, act_l, act_r, e.kind, e.l, e.r, prev_l);
        if (!ok) n_fail++;
        else if (e.kind == K_EXACT)
          $display("sample %s: L=%0d R=%0d", e.name, act_l, act_r);
        prev_l = act_l;
      end
    end
    prev_ov <= out_valid && !reset;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; write = 1'b1;
    $display("write reg%0d = %0d", a, d);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_pulse();
    bit seen = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL pulse_timeout: no out_valid within %0d cycles, required one", 3 * CLK_DIV);
    end
  endtask

  task automatic settle();
    wait_pulse();
    wait_pulse();
    @(posedge clk);
  endtask

  task automatic push(input int kind, input int l, input int r, input string name, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{kind, l, r, name});
  endtask

  task automatic drain();
    int bound = (sb.size() + 3) * CLK_DIV + 20;
    while (sb.size() > 0 && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    if (sb.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d expected samples never appeared, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic first_pulse_latency(input string name);
    int k = 0;
    for (int i = 1; i <= CLK_DIV + 8; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    chk(name, k, 4);
  endtask

  initial begin
    int k;
    reset = 1'b1; write = 1'b0; addr = '0; data_in = '0; audio_in = 12'h100;
    repeat (3) @(negedge clk);
    chk("reset_audio_l", audio_l, 0);
    chk("reset_audio_r", audio_r, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_fading", fading, 0);
    push(K_EXACT, 4080, 4080, "first_after_reset", 1);
    reset = 1'b0;
    first_pulse_latency("reset_release_latency");
    drain();

    // DC block off, unity path
    wr(4'd5, 8'd0);
    settle();
    push(K_EXACT, 4080, 4080, "dc_off_256", 3);
    drain();
    wait_pulse();
    k = 0;
    for (int i = 1; i <= 2 * CLK_DIV; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    chk("sample_period", k, CLK_DIV);

    // Gains and saturation
    wr(4'd1, 8'd255);
    wr(4'd2, 8'd0);
    audio_in = 12'h7FF;
    settle();
    push(K_EXACT, 32767, 0, "sat_pos", 2);
    drain();
    audio_in = 12'h800;
    settle();
    push(K_EXACT, -32768, 0, "sat_neg", 1);
    drain();
    wr(4'd1, 8'd64);
    wr(4'd2, 8'd200);
    audio_in = 12'h100;
    settle();
    push(K_EXACT, 2040, 6375, "gain_pos", 1);
    drain();
    audio_in = 12'hF00;
    settle();
    push(K_EXACT, -2040, -6375, "gain_neg", 1);
    drain();

    // Mute keeps pulsing with zero output
    wr(4'd1, 8'd128);
    wr(4'd2, 8'd128);
    audio_in = 12'h100;
    wr(4'd5, 8'd1);
    settle();
    push(K_EXACT, 0, 0, "muted", 3);
    drain();
    wr(4'd5, 8'd0);
    settle();
    push(K_EXACT, 4080, 4080, "unmuted", 1);
    drain();

    // Timed fade 255 -> 250 at 2 samples per step
    wr(4'd4, 8'd2);
    wr(4'd3, 8'd250);
    chk("fading_after_target", fading, 1);
    k = 0;
    for (int i = 0; i < 20 * CLK_DIV; i++) begin
      if (!fading) break;
      if (out_valid) k++;
      @(negedge clk);
    end
    chk("fade_samples", k, 10);
    settle();
    push(K_EXACT, 4000, 4000, "vol_250", 1);
    drain();

    // Master volume write collides with a scheduled fade step
    wr(4'd3, 8'd200);
    wait_pulse();
    repeat (CLK_DIV) @(negedge clk);
    chk("collision_on_pulse", out_valid, 1);
    addr = 4'd0; data_in = 8'd100; write = 1'b1;
    $display("write reg0 = 100 (on step pulse)");
    @(negedge clk);
    write = 1'b0;
    chk("fading_after_master", fading, 0);
    settle();
    push(K_EXACT, 1600, 1600, "vol_100", 1);
    drain();

    // Reset two cycles after a strobe flushes the in-flight sample
    wait_pulse();
    repeat (CLK_DIV - 4 + 2) @(negedge clk);
    push(K_EXACT, 4080, 4080, "first_after_midreset", 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_audio_l", audio_l, 0);
    chk("midreset_audio_r", audio_r, 0);
    first_pulse_latency("midreset_latency");
    drain();

    // DC block: step input decays toward zero
    audio_in = 12'h200;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push(K_EXACT, 8160, 8160, "dc_first", 1);
    push(K_DECAY, 0, 0, "dc_decay", 1399);
    push(K_SETTLED, 0, 0, "dc_settled", 1);
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_mixer.md
# sound_mixer

Output stage directly downstream of the sound engine (ADPCM voice). It resamples the engine's 12-bit signed `audio_in` onto a fixed output-rate strobe and removes DC offset with a leaky high-pass. It applies a CPU-controlled master volume with timed fades, then per-channel gains with saturation, and drives the 16-bit stereo pair to the platform audio output. It shares the CPU register-bus style (`addr`/`data_in`/`write`) of the sound engine on its own address decode.

## Interface
- `CLK_DIV`, 250, clk cycles per output sample (12 MHz / 250 = 48 kHz); valid range 8..65535
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `addr`  in  4  register address
- `data_in`  in  8  register write data
- `write`  in  1  register write strobe, one cycle
- `audio_in`  in  12  signed two's-complement voice sample from the sound engine
- `audio_l`  out  16  signed left output
- `audio_r`  out  16  signed right output
- `out_valid`  out  1  one-cycle pulse when `audio_l`/`audio_r` update
- `fading`  out  1  high while current volume != fade target

## Operation
- Registers (unmapped addresses are ignored):
  - 0: master volume. Sets `cur_vol` and `tgt_vol` together and cancels any fade.
  - 1: left gain `g_l`.
  - 2: right gain `g_r`.
  - 3: fade target `tgt_vol`.
  - 4: fade rate `rate`, in output samples per step.
  - 5: control. bit0 = mute, bit1 = DC-block enable.
- Reset values:
  - `cur_vol` = `tgt_vol` = 255
  - `g_l` = `g_r` = 128
  - `rate` = 0
  - mute = 0, DC enable = 1
  - DC accumulator = 0
  - all outputs 0
- Strobe: a counter counts 0..`CLK_DIV`-1 and `strobe` asserts on count 0. The counter restarts at 0 on reset.
- Pipeline, one stage per cycle, advanced by `strobe`:
  - S0: `x` = sign-extended `audio_in` <<< 4, 16-bit.
  - S1 (DC block): `m` = `acc` >>> 8 (24-bit signed `acc`). `y` = `x` − `m`, saturated to 16 bits. Then `acc` <= `acc` + `y`. With DC enable = 0, `y` = `x` and `acc` is held.
  - S2: `v` = (`y` × `cur_vol`) >>> 8, 25-bit signed product, result always fits 16 bits.
  - S3: `L` = (`v` × `g_l`) >>> 7 and `R` = (`v` × `g_r`) >>> 7. Each is saturated to [−32768, 32767]. Mute forces both to 0. The outputs register and `out_valid` pulses.
- Fade (evaluated on each `out_valid`):
  - If `cur_vol` != `tgt_vol`, increment `fade_cnt`.
  - When `fade_cnt` reaches `rate`: step `cur_vol` by ±1 toward `tgt_vol` and clear `fade_cnt`.
  - `rate` = 0 means a write to reg 3 copies to `cur_vol` immediately.
  - Writing reg 3 or reg 4 clears `fade_cnt`.
- `fading` = (`cur_vol` != `tgt_vol`), combinational from registers.

## Timing
- Latency: `audio_in` is sampled on the `strobe` cycle. Outputs and `out_valid` appear 4 cycles later (S0..S3 registered).
- Outputs hold between pulses. `out_valid` is never high on two consecutive cycles.
- Register writes take effect the cycle after `write`. A sample in flight uses each register's value at the cycle of the stage that reads it.
- Simultaneous events:
  - A reg 0 write in the same cycle as a fade step: the write wins.
  - A reg 3 write during a fade retargets without glitch; `cur_vol` is unchanged that cycle.
- Mute does not stall the pipeline or freeze `acc`. Unmute is effective on the next S3.
- Reset mid-pipeline: all stages flush, `acc` clears, and no `out_valid` fires until 4 cycles after the first post-reset strobe.
- `cur_vol` saturates at 0 and 255. There is no wrap.

## Test plan
- Reset, DC enable off, `audio_in` = 12'h100 (256) → `audio_l` = `audio_r` = (4096 × 255 >>> 8) × 128 >>> 7 = 4080. `out_valid` pulses every 250 cycles, 4 cycles after strobe.
- `g_l` = 255, `g_r` = 0, `audio_in` = 12'h7FF → `audio_l` saturates to 32767, `audio_r` = 0. With `audio_in` = 12'h800 → `audio_l` = −32768.
- DC enable on, constant `audio_in` = 12'h200 → the first output is about 8160. The output decays monotonically toward 0 and settles to |out| < 64 within 3000 samples.
- `rate` = 2, reg 3 = 250 from `cur_vol` 255 → `cur_vol` steps down once every 2 `out_valid`. `fading` drops after exactly 10 output samples.
- Write reg 0 = 100 mid-fade on the same cycle as a scheduled step → `cur_vol` = 100 and `fading` = 0 next cycle.
- Mute with a nonzero input → outputs = 0 while `out_valid` keeps pulsing. Assert `reset` 2 cycles after a strobe → no `out_valid` from that sample, and outputs = 0.
